// File: rtl/regfile_mp_if.sv
// Register-file bundle: writeback lanes, read ports, and scoreboard mark/flush with status.
// Master drives writes, reads and marks. Slave returns read data and busy status.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                we0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                we1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                mark_en;
  logic [AW-1:0]       mark_addr;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, mark_en, mark_addr, flush,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, mark_en, mark_addr, flush,
    output rdata, rbusy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard. Reads are combinational and bypass writeback.
// Writes and busy updates take effect on the next edge. There is no backpressure: the consumer stalls on rbusy.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave rf
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [XLEN-1:0]     mem_d [NREGS];
  logic [NREGS-1:0]    busy_q;
  logic [NREGS-1:0]    busy_d;
  logic [NRD*XLEN-1:0] rdata_d;
  logic [NRD-1:0]      rbusy_d;
  logic [AW-1:0]       ra;
  logic                hit0;
  logic                hit1;

  // Lane 1 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (rf.we0) mem_d[rf.waddr0] = rf.wdata0;
    if (rf.we1) mem_d[rf.waddr1] = rf.wdata1;
    if (ZERO_REG) mem_d[0] = '0;
  end

  // A mark comes from a younger producer, so it overrides both flush and writeback.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (rf.mark_en && rf.mark_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if (rf.flush) begin
        busy_d[r] = 1'b0;
      end else if ((rf.we0 && rf.waddr0 == AW'(r)) || (rf.we1 && rf.waddr1 == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    rbusy_d = '0;
    ra      = '0;
    hit0    = 1'b0;
    hit1    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra   = rf.raddr[i*AW +: AW];
      hit1 = rf.we1 && (rf.waddr1 == ra);
      hit0 = rf.we0 && (rf.waddr0 == ra);
      if (ZERO_REG && ra == '0) begin
        rdata_d[i*XLEN +: XLEN] = '0;
        rbusy_d[i]              = 1'b0;
      end else begin
        if (hit1)      rdata_d[i*XLEN +: XLEN] = rf.wdata1;
        else if (hit0) rdata_d[i*XLEN +: XLEN] = rf.wdata0;
        else           rdata_d[i*XLEN +: XLEN] = mem_q[ra];
        rbusy_d[i] = busy_q[ra] && !(hit0 || hit1);
      end
    end
  end

  assign rf.rdata    = rdata_d;
  assign rf.rbusy    = rbusy_d;
  assign rf.busy_vec = busy_q;
endmodule
